// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the shared-ALU operand/result
// lines and the response channel of alu_arbiter.
// Ports (modport slave = arbiter side):
//   req0_*/req1_* : valid/ready request channels carrying op, x, y
//   alu_*         : registered operands out to the ALU, alu_w result back in
//   rsp_*         : valid/ready response channel carrying id and captured result
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 7
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_w;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_w;

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_op, req1_x, req1_y,
    output req1_ready,
    output alu_op, alu_x, alu_y,
    input  alu_w,
    output rsp_valid, rsp_id, rsp_w,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_op, req1_x, req1_y,
    input  req1_ready,
    input  alu_op, alu_x, alu_y,
    output alu_w,
    input  rsp_valid, rsp_id, rsp_w,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Latency: rsp_valid rises 1 edge after accept (MUL_LAT edges for MUL); one op in flight.
// Backpressure: requesters see ready only in IDLE; the response is held until rsp_ready.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus_if : request channels, ALU operand/result lines, response channel (slave side)
module alu_arbiter #(
  parameter int              WIDTH   = 32,
  parameter int              OP_W    = 7,
  parameter int              MUL_LAT = 4,
  parameter logic [OP_W-1:0] OP_MUL  = OP_W'(2)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus_if
);

  // Counter only has to hold MUL_LAT-1.
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d;
  logic [WIDTH-1:0] alu_y_q, alu_y_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_w_q, rsp_w_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;

  // Pointer side wins when valid; otherwise the other side (which must then be valid).
  assign gnt_vld = (state_q == IDLE) && (bus_if.req0_valid || bus_if.req1_valid);
  assign gnt_id  = ptr_q ? bus_if.req1_valid : ~bus_if.req0_valid;

  assign bus_if.req0_ready = gnt_vld && !gnt_id;
  assign bus_if.req1_ready = gnt_vld &&  gnt_id;

  assign sel_op = gnt_id ? bus_if.req1_op : bus_if.req0_op;
  assign sel_x  = gnt_id ? bus_if.req1_x  : bus_if.req0_x;
  assign sel_y  = gnt_id ? bus_if.req1_y  : bus_if.req0_y;

  assign bus_if.alu_op    = alu_op_q;
  assign bus_if.alu_x     = alu_x_q;
  assign bus_if.alu_y     = alu_y_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_id    = rsp_id_q;
  assign bus_if.rsp_w     = rsp_w_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_w_d     = rsp_w_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          alu_op_d = sel_op;
          alu_x_d  = sel_x;
          alu_y_d  = sel_y;
          rsp_id_d = gnt_id;
          ptr_d    = ~gnt_id;
          // Non-MUL results are sampled on the very next edge.
          cnt_d    = (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_w_d     = bus_if.alu_w;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_w_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_w_q     <= rsp_w_d;
    end
  end

endmodule
